// File: rtl/axi4lite_cernbe_xbar.sv
// AXI4-Lite slave fanning out to N_SUB CERN-BE memory-style sub-buses.
// One outstanding transaction; DECERR on unmapped, SLVERR on done timeout.
module axi4lite_cernbe_xbar #(
  parameter int DATA_WIDTH    = 32,
  parameter int SUB_ADDR_BITS = 12,
  parameter int N_SUB         = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int PIPE          = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [ADDR_WIDTH-1:0]       awaddr,
  input  logic [2:0]                  awprot,
  input  logic                        wvalid,
  output logic                        wready,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  output logic                        bvalid,
  input  logic                        bready,
  output logic [1:0]                  bresp,
  input  logic                        arvalid,
  output logic                        arready,
  input  logic [ADDR_WIDTH-1:0]       araddr,
  input  logic [2:0]                  arprot,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [1:0]                  rresp,
  output logic [SUB_ADDR_BITS-1:0]    sub_addr_o,
  output logic [DATA_WIDTH-1:0]       sub_wr_data_o,
  input  logic [N_SUB*DATA_WIDTH-1:0] sub_rd_data_i,
  output logic [N_SUB-1:0]            sub_wr_mem_o,
  output logic [N_SUB-1:0]            sub_rd_mem_o,
  input  logic [N_SUB-1:0]            sub_wr_done_i,
  input  logic [N_SUB-1:0]            sub_rd_done_i
);
  localparam int IDX_W = (N_SUB > 1) ? $clog2(N_SUB) : 1;
  localparam int LSB   = $clog2(DATA_WIDTH / 8);
  localparam int HI    = SUB_ADDR_BITS + IDX_W;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_STAGE, S_STROBE, S_RESP
  } state_t;

  state_t state_q, state_d;
  logic aw_q, aw_d, w_q, w_d, ar_q, ar_d;
  logic is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUB_ADDR_BITS-1:0] saddr_q, saddr_d;
  logic [DATA_WIDTH-1:0] swdata_q, swdata_d;
  logic [N_SUB-1:0] wmem_q, wmem_d, rmem_q, rmem_d;
  logic [15:0] cnt_q, cnt_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_sel;

  logic aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [IDX_W-1:0] dec_idx;
  logic dec_err, sub_done;
  logic [N_SUB-1:0] dec_hot, sel_hot;
  logic unused;

  assign unused = ^{awprot, arprot, wstrb};

  assign awready = ~aw_q;
  assign wready  = ~w_q;
  assign arready = ~ar_q;
  assign aw_hs   = awvalid & ~aw_q;
  assign w_hs    = wvalid & ~w_q;
  assign ar_hs   = arvalid & ~ar_q;

  assign bvalid        = bvalid_q;
  assign rvalid        = rvalid_q;
  assign bresp         = resp_q;
  assign rresp         = resp_q;
  assign rdata         = rdata_q;
  assign sub_addr_o    = saddr_q;
  assign sub_wr_data_o = swdata_q;
  assign sub_wr_mem_o  = wmem_q;
  assign sub_rd_mem_o  = rmem_q;

  assign dec_addr = is_wr_q ? awaddr_q : araddr_q;
  assign dec_idx  = dec_addr[SUB_ADDR_BITS +: IDX_W];
  assign dec_err  = ((dec_addr >> HI) != '0)
                 || (int'(dec_idx) >= N_SUB);
  assign dec_hot  = N_SUB'(1) << dec_idx;
  assign sel_hot  = N_SUB'(1) << idx_q;
  assign sub_done = is_wr_q ? sub_wr_done_i[idx_q]
                            : sub_rd_done_i[idx_q];

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_SUB; k++)
      if (idx_q == IDX_W'(k))
        rd_sel = sub_rd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    aw_d     = aw_q | aw_hs;
    w_d      = w_q | w_hs;
    ar_d     = ar_q | ar_hs;
    is_wr_d  = is_wr_q;
    idx_d    = idx_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    wmem_d   = wmem_q;
    rmem_d   = rmem_q;
    cnt_d    = cnt_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    resp_d   = resp_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        // a complete write takes priority over a pending read
        if ((aw_q | aw_hs) && (w_q | w_hs)) begin
          is_wr_d = 1'b1;
          state_d = S_DECODE;
        end else if (ar_q | ar_hs) begin
          is_wr_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        idx_d   = dec_idx;
        saddr_d = dec_addr[SUB_ADDR_BITS-1:0]
                & ~SUB_ADDR_BITS'((1 << LSB) - 1);
        if (is_wr_q) swdata_d = wdata_q;
        if (dec_err) begin
          resp_d   = 2'b11;
          if (!is_wr_q) rdata_d = '0;
          bvalid_d = is_wr_q;
          rvalid_d = ~is_wr_q;
          state_d  = S_RESP;
        end else if (PIPE != 0) begin
          state_d = S_STAGE;
        end else begin
          cnt_d   = '0;
          wmem_d  = is_wr_q ? dec_hot : '0;
          rmem_d  = is_wr_q ? '0 : dec_hot;
          state_d = S_STROBE;
        end
      end
      S_STAGE: begin
        cnt_d   = '0;
        wmem_d  = is_wr_q ? sel_hot : '0;
        rmem_d  = is_wr_q ? '0 : sel_hot;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        // done in the final counted cycle still wins over the timeout
        if (sub_done || cnt_q == TMO_LAST) begin
          wmem_d   = '0;
          rmem_d   = '0;
          bvalid_d = is_wr_q;
          rvalid_d = ~is_wr_q;
          state_d  = S_RESP;
          resp_d   = sub_done ? 2'b00 : 2'b10;
          if (!is_wr_q) rdata_d = sub_done ? rd_sel : '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_d = 1'b0;
          aw_d     = 1'b0;
          w_d      = 1'b0;
          state_d  = S_IDLE;
        end else if (rvalid_q && rready) begin
          rvalid_d = 1'b0;
          ar_d     = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      if (aw_hs) awaddr_q <= awaddr;
      if (ar_hs) araddr_q <= araddr;
      if (w_hs)  wdata_q  <= wdata;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      ar_q     <= 1'b0;
      is_wr_q  <= 1'b0;
      idx_q    <= '0;
      saddr_q  <= '0;
      swdata_q <= '0;
      wmem_q   <= '0;
      rmem_q   <= '0;
      cnt_q    <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      resp_q   <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      aw_q     <= aw_d;
      w_q      <= w_d;
      ar_q     <= ar_d;
      is_wr_q  <= is_wr_d;
      idx_q    <= idx_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      wmem_q   <= wmem_d;
      rmem_q   <= rmem_d;
      cnt_q    <= cnt_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi4lite_cernbe_xbar.sv
// Directed bench for axi4lite_cernbe_xbar: vector table plus
// hand-written sequences for ordering, priority, timeout and reset.
module tb_axi4lite_cernbe_xbar;
  logic        aclk;
  logic        areset;
  logic        awvalid, awready;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [15:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [11:0] sub_addr_o;
  logic [31:0] sub_wr_data_o;
  logic [127:0] sub_rd_data_i;
  logic [3:0]  sub_wr_mem_o, sub_rd_mem_o;
  logic [3:0]  sub_wr_done_i, sub_rd_done_i;

  axi4lite_cernbe_xbar #(
    .DATA_WIDTH(32), .SUB_ADDR_BITS(12), .N_SUB(4),
    .ADDR_WIDTH(16), .PIPE(1), .TIMEOUT(8)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp),
    .sub_addr_o(sub_addr_o), .sub_wr_data_o(sub_wr_data_o),
    .sub_rd_data_i(sub_rd_data_i),
    .sub_wr_mem_o(sub_wr_mem_o), .sub_rd_mem_o(sub_rd_mem_o),
    .sub_wr_done_i(sub_wr_done_i), .sub_rd_done_i(sub_rd_done_i)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // sub model: done after dly strobe cycles unless never is set
  int   scnt = 0;
  int   dly = 0;
  bit   never = 0;
  logic [3:0] extra_wr = '0, extra_rd = '0;
  logic fire;
  always @(posedge aclk)
    if ((sub_wr_mem_o | sub_rd_mem_o) != 0) scnt <= scnt + 1;
    else scnt <= 0;
  assign fire = !never && (scnt == dly);
  assign sub_wr_done_i = (fire ? sub_wr_mem_o : 4'h0) | extra_wr;
  assign sub_rd_done_i = (fire ? sub_rd_mem_o : 4'h0) | extra_rd;
  assign sub_rd_data_i = {32'h12345678, 32'h22220002,
                          32'h11110001, 32'hC0DE0000};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // results of the last wait_resp
  logic [3:0]  wm, rm;
  int          width, first, edges;
  logic [1:0]  resp;
  logic [31:0] rd, sd;
  logic [11:0] sa;
  logic [2:0]  rdy;
  bit          overlap;

  task automatic wait_resp(input bit wr);
    bit got;
    bit prev;
    logic [3:0] cur;
    got = 0; prev = 0; wm = 0; rm = 0;
    width = 0; first = 0; edges = 0; overlap = 0;
    resp = 'x; rd = 'x; sa = 'x; sd = 'x; rdy = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(negedge aclk);
      cur = sub_wr_mem_o | sub_rd_mem_o;
      if (cur != 0) begin
        if (width == 0) begin
          first = i; sa = sub_addr_o; sd = sub_wr_data_o;
        end
        width++;
        if (!prev) edges++;
      end
      if ((sub_wr_mem_o != 0 && sub_rd_mem_o != 0)
          || $countones(cur) > 1) overlap = 1;
      wm |= sub_wr_mem_o;
      rm |= sub_rd_mem_o;
      prev = (cur != 0);
      if (wr ? bvalid : rvalid) begin
        resp = wr ? bresp : rresp;
        rd = rdata;
        rdy = {awready, wready, arready};
        got = 1;
        break;
      end
    end
    chk("resp_seen", 64'(got), 64'd1);
    if (got) begin
      if (wr) bready = 1; else rready = 1;
      @(posedge aclk); #1;
      bready = 0; rready = 0;
      @(negedge aclk);
    end
  endtask

  task automatic do_txn(input bit wr, input logic [15:0] a,
                        input logic [31:0] d);
    @(negedge aclk);
    if (wr) begin
      awvalid = 1; awaddr = a; wvalid = 1; wdata = d;
    end else begin
      arvalid = 1; araddr = a;
    end
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    wait_resp(wr);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    int          dly;
    bit          never;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [3:0]  mask;
    int          width;
    logic [11:0] saddr;
  } vec_t;

  vec_t v[10];

  initial begin
    bit seen;
    areset = 1; awvalid = 0; awaddr = 0; awprot = 0;
    wvalid = 0; wdata = 0; wstrb = 4'hF; bready = 0;
    arvalid = 0; araddr = 0; arprot = 0; rready = 0;

    v[0] = '{1, 16'h1004, 32'hDEADBEEF, 2, 0, 2'b00, 0, 4'b0010, 3, 12'h004};
    v[1] = '{0, 16'h3008, 0, 0, 0, 2'b00, 32'h12345678, 4'b1000, 1, 12'h008};
    v[2] = '{0, 16'h0FFC, 0, 1, 0, 2'b00, 32'hC0DE0000, 4'b0001, 2, 12'hFFC};
    v[3] = '{1, 16'h2FFE, 32'h0BADF00D, 0, 0, 2'b00, 0, 4'b0100, 1, 12'hFFC};
    v[4] = '{0, 16'h4000, 0, 0, 0, 2'b11, 0, 4'b0000, 0, 0};
    v[5] = '{0, 16'h8010, 0, 0, 0, 2'b11, 0, 4'b0000, 0, 0};
    v[6] = '{1, 16'hC000, 32'h55AA55AA, 0, 0, 2'b11, 0, 4'b0000, 0, 0};
    v[7] = '{0, 16'h1010, 0, 0, 1, 2'b10, 0, 4'b0010, 8, 12'h010};
    v[8] = '{1, 16'h3000, 32'h01020304, 0, 1, 2'b10, 0, 4'b1000, 8, 12'h000};
    v[9] = '{0, 16'h2004, 0, 7, 0, 2'b00, 32'h22220002, 4'b0100, 8, 12'h004};

    repeat (2) @(negedge aclk);
    chk("rst_ready", 64'({awready, wready, arready}), 64'h7);
    chk("rst_valid", 64'({bvalid, rvalid}), 64'h0);
    chk("rst_resp", 64'({bresp, rresp}), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_strobe", 64'({sub_wr_mem_o, sub_rd_mem_o}), 64'h0);
    chk("rst_sub", 64'({sub_addr_o, sub_wr_data_o}), 64'h0);
    areset = 0;

    for (int i = 0; i < 10; i++) begin
      dly = v[i].dly; never = v[i].never;
      do_txn(v[i].wr, v[i].addr, v[i].data);
      chk($sformatf("v%0d_resp", i), 64'(resp), 64'(v[i].resp));
      if (!v[i].wr)
        chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(v[i].rdata));
      chk($sformatf("v%0d_mask", i), 64'({wm, rm}),
          v[i].wr ? 64'({v[i].mask, 4'h0}) : 64'({4'h0, v[i].mask}));
      chk($sformatf("v%0d_width", i), 64'(width), 64'(v[i].width));
      chk($sformatf("v%0d_overlap", i), 64'(overlap), 64'd0);
      chk($sformatf("v%0d_ready", i), 64'(rdy),
          v[i].wr ? 64'h1 : 64'h6);
      if (v[i].mask != 0) begin
        chk($sformatf("v%0d_saddr", i), 64'(sa), 64'(v[i].saddr));
        chk($sformatf("v%0d_latency", i), 64'(first), 64'd3);
        if (v[i].wr)
          chk($sformatf("v%0d_wdata", i), 64'(sd), 64'(v[i].data));
      end
    end
    never = 0;

    // W one cycle before AW
    dly = 1;
    @(negedge aclk);
    wvalid = 1; wdata = 32'hA1A1A1A1;
    @(posedge aclk); #1; wvalid = 0;
    @(negedge aclk);
    chk("wfirst_wready_low", 64'(wready), 64'd0);
    chk("wfirst_no_strobe", 64'(sub_wr_mem_o), 64'd0);
    awvalid = 1; awaddr = 16'h2010;
    @(posedge aclk); #1; awvalid = 0;
    wait_resp(1);
    chk("wfirst_edges", 64'(edges), 64'd1);
    chk("wfirst_mask", 64'(wm), 64'b0100);
    chk("wfirst_wdata", 64'(sd), 64'hA1A1A1A1);
    chk("wfirst_ready_low", 64'(rdy[2:1]), 64'd0);
    chk("wfirst_ready_back", 64'({awready, wready}), 64'h3);

    // AW one cycle before W
    @(negedge aclk);
    awvalid = 1; awaddr = 16'h0020;
    @(posedge aclk); #1; awvalid = 0;
    @(negedge aclk);
    chk("awfirst_awready_low", 64'(awready), 64'd0);
    chk("awfirst_no_strobe", 64'(sub_wr_mem_o), 64'd0);
    wvalid = 1; wdata = 32'hB2B2B2B2;
    @(posedge aclk); #1; wvalid = 0;
    wait_resp(1);
    chk("awfirst_edges", 64'(edges), 64'd1);
    chk("awfirst_mask", 64'(wm), 64'b0001);
    chk("awfirst_wdata", 64'(sd), 64'hB2B2B2B2);
    chk("awfirst_ready_low", 64'(rdy[2:1]), 64'd0);
    chk("awfirst_ready_back", 64'({awready, wready}), 64'h3);
    repeat (3) begin
      @(negedge aclk);
      chk("awfirst_no_extra", 64'(sub_wr_mem_o), 64'd0);
    end

    // write and read in the same IDLE cycle: write first
    dly = 0;
    @(negedge aclk);
    awvalid = 1; awaddr = 16'h1000; wvalid = 1; wdata = 32'hC3C3C3C3;
    arvalid = 1; araddr = 16'h3000;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    wait_resp(1);
    chk("prio_wr_mask", 64'({wm, rm}), 64'h20);
    chk("prio_wr_resp", 64'(resp), 64'd0);
    chk("prio_ar_held", 64'(rdy), 64'd0);
    wait_resp(0);
    chk("prio_rd_mask", 64'({wm, rm}), 64'h08);
    chk("prio_rd_data", 64'(rd), 64'h12345678);

    // done from non-selected subs is ignored
    dly = 3; extra_rd = 4'b1011;
    do_txn(0, 16'h2000, 0);
    extra_rd = 4'b0000;
    chk("nonsel_width", 64'(width), 64'd4);
    chk("nonsel_rdata", 64'(rd), 64'h22220002);

    // timeout then late done from the same sub
    never = 1;
    do_txn(0, 16'h1000, 0);
    chk("late_tmo_resp", 64'(resp), 64'd2);
    never = 0; dly = 2;
    extra_rd = 4'b0010;
    repeat (3) @(negedge aclk);
    extra_rd = 4'b0000;
    do_txn(0, 16'h1000, 0);
    chk("late_next_resp", 64'(resp), 64'd0);
    chk("late_next_width", 64'(width), 64'd3);
    chk("late_next_rdata", 64'(rd), 64'h11110001);

    // asynchronous reset while strobing
    never = 1;
    @(negedge aclk);
    arvalid = 1; araddr = 16'h1000;
    @(posedge aclk); #1; arvalid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge aclk);
      seen = (sub_rd_mem_o != 0);
    end
    chk("arst_strobe_seen", 64'(seen), 64'd1);
    areset = 1;
    #1;
    chk("arst_strobe", 64'({sub_wr_mem_o, sub_rd_mem_o}), 64'd0);
    chk("arst_valid", 64'({bvalid, rvalid}), 64'd0);
    chk("arst_ready", 64'({awready, wready, arready}), 64'h7);
    @(negedge aclk);
    areset = 0;
    never = 0; dly = 0;
    do_txn(0, 16'h3000, 0);
    chk("arst_next_resp", 64'(resp), 64'd0);
    chk("arst_next_rdata", 64'(rd), 64'h12345678);
    chk("arst_next_mask", 64'(rm), 64'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
